icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Parametrised successor to the single-word-line fetch stage.
- Holds the PC and a direct-mapped I-cache with multi-word lines, each refilled by a sequential word-burst FSM over a one-outstanding-request memory port.
- Presents one instruction per cycle on a hit. Handles branch redirects, downstream stalls and fence.i flushes at any point, including mid-refill.
- Sits between the memory controller and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.
- LINES, 64, number of cache lines; power of 2, >=2.
- WORDS, 4, instructions per line; power of 2, >=1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall_i  in  1  downstream stall; hold PC and outputs.
- redirect_i  in  1  branch/jump taken.
- redirect_pc_i  in  ADDR_W  redirect target, word aligned.
- flush_i  in  1  fence.i; invalidate whole cache.
- pc_o  out  ADDR_W  PC of inst_o.
- inst_o  out  INST_W  instruction; 0 when inst_valid_o=0.
- inst_valid_o  out  1  inst_o valid this cycle.
- mem_req_o  out  1  word read request.
- mem_addr_o  out  ADDR_W  word address of request.
- mem_ack_i  in  1  request accepted, data present.
- mem_rdata_i  in  INST_W  returned word, valid with mem_ack_i.
- refill_busy_o  out  1  FSM in REFILL.

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Reset values:
  - pc_o=RESET_PC; all valid bits 0; FSM=IDLE.
  - mem_req_o=0, mem_addr_o=0, inst_o=0, inst_valid_o=0, refill_busy_o=0.
  - Internal counters and flags cleared.
- Address split:
  - bits[1:0] ignored.
  - offset = next log2(WORDS) bits.
  - index = next log2(LINES) bits.
  - tag = remaining bits.
- Hit:
  - Defined as FSM=IDLE, valid[index(pc)] set, and tag match; evaluated combinationally on pc_o.
  - On a hit: inst_valid_o=1 and inst_o=data[index][offset] in the same cycle (zero-cycle hit latency).
- PC update each cycle, in priority order:
  1. rst.
  2. redirect_i: pc<=redirect_pc_i, even when stall_i=1 or in REFILL.
  3. stall_i: hold.
  4. hit: pc<=pc+4, wrapping modulo 2^ADDR_W.
  5. Otherwise hold.
- FSM, IDLE -> REFILL:
  - Triggered on a miss with redirect_i=0 and flush_i=0.
  - Latch miss line base = {tag,index,0}; word counter cnt=0.
- REFILL:
  - mem_req_o=1, mem_addr_o = line base + cnt*4.
  - Request and address stay stable until mem_ack_i.
  - On ack: data[index][cnt]<=mem_rdata_i, cnt++.
  - Requests are issued in order, offset 0..WORDS-1. No critical-word-first, no forwarding.
- REFILL -> IDLE: on the ack of word WORDS-1.
  - Tag written.
  - Valid bit set unless a flush occurred during the refill.
  - Next cycle the original PC hits. Total miss penalty = sum of ack latencies + 1 cycle.
- Redirect during REFILL: the refill runs to completion and the line is installed. The new PC is looked up once back in IDLE.
- flush_i:
  - Clears all valid bits next edge.
  - In REFILL, sets flush_pending; the completing line is written but left invalid, and flush_pending is cleared.
  - Flush in the same cycle as a hit still delivers that hit.
- Stall with miss: the FSM still refills; stall only freezes the PC.
- inst_valid_o=0 whenever in REFILL or on a miss cycle.
- mem_ack_i while mem_req_o=0 is ignored.
- rst mid-refill: abandon the refill immediately and deassert mem_req_o next edge. The partially written line stays invalid.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, adds outputs:
  - hit_cnt_o, 32-bit: increments on cycles with a hit and stall_i=0.
  - miss_cnt_o, 32-bit: increments on each IDLE->REFILL transition.
- Both counters saturate at 0xFFFFFFFF, are cleared by rst, and are unaffected by flush_i.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Cold miss at reset, WORDS=4, memory acks 2 cycles after each req:
  - Required request addresses 0x0, 0x4, 0x8, 0xC.
  - inst_valid_o=1 with pc_o=0 on the cycle after the 4th ack.
  - Then 4 consecutive hit cycles, pc_o 0x0→0xC.
- Redirect: redirect_i=1, redirect_pc_i=0x100 during the 2nd refill word.
  - Refill of line 0 completes.
  - pc_o=0x100 next edge.
  - New refill of 0x100–0x10C follows.
  - A later jump to 0x4 hits with no memory request.
- Conflict (LINES=64, WORDS=4): fetch 0x0, then redirect to 0x400, same index.
  - 0x400 causes a refill.
  - A redirect back to 0x0 misses again.
- Stall: stall_i=1 for 3 cycles during hits.
  - pc_o and inst_o held.
  - Then redirect_i with stall_i=1 still moves pc_o to the target.
- Flush: flush_i during the 3rd refill word.
  - The line completes but the same PC misses again and re-requests the line.
  - A flush while idle makes all previously cached PCs miss.
- rst asserted mid-refill:
  - mem_req_o=0 and pc_o=RESET_PC next cycle.
  - The fetch at RESET_PC misses, proving the partial line is invalid.

Source files
------------

// File: rtl/icache_fetch.sv
// Fetch stage: PC register plus a direct-mapped I-cache with multi-word lines,
// refilled word by word over a one-outstanding-request port. Define ICACHE_PERF_EN for hit/miss counters.
module icache_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                LINES    = 64,
  parameter int                WORDS    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              refill_busy_o
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_B   = $clog2(WORDS);
  localparam int IDX_B   = $clog2(LINES);
  localparam int OFF_W   = (OFF_B > 0) ? OFF_B : 1;
  localparam int TAG_LSB = 2 + OFF_B + IDX_B;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS * 4 - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  function automatic logic [IDX_B-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_B'(a >> (2 + OFF_B));
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
    return OFF_W'((a >> 2) & ADDR_W'(WORDS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> TAG_LSB);
  endfunction

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  cnt;
  logic              flush_pending;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES][WORDS];

  logic [IDX_B-1:0]  pc_idx, base_idx;
  logic [OFF_W-1:0]  pc_off;
  logic              hit, ack, last, start;

  assign pc_idx   = idx_of(pc);
  assign pc_off   = off_of(pc);
  assign base_idx = idx_of(base);
  assign hit      = (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == tag_of(pc));
  assign ack      = (state == REFILL) && mem_ack_i;
  assign last     = ack && (cnt == OFF_W'(WORDS - 1));
  assign start    = (state == IDLE) && (state_next == REFILL);
  assign pc_o     = pc;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next    = state;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    refill_busy_o = 1'b0;
    inst_valid_o  = 1'b0;
    inst_o        = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          inst_valid_o = 1'b1;
          inst_o       = data_mem[pc_idx][pc_off];
        end else if (!redirect_i && !flush_i) begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        mem_req_o     = 1'b1;
        refill_busy_o = 1'b1;
        mem_addr_o    = base | (ADDR_W'(cnt) << 2);
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Redirect wins over stall and over an in-flight refill.
  always_ff @(posedge clk) begin
    if (rst)              pc <= RESET_PC;
    else if (redirect_i)  pc <= redirect_pc_i;
    else if (!stall_i && hit) pc <= pc + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base          <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else if (start) begin
      base          <= pc & ~LINE_MASK;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else if (state == REFILL) begin
      if (ack) cnt <= cnt + OFF_W'(1);
      if (last)         flush_pending <= 1'b0;
      else if (flush_i) flush_pending <= 1'b1;
    end
  end

  // A flush on the final ack also leaves the new line invalid.
  always_ff @(posedge clk) begin
    if (rst || flush_i)               valid <= '0;
    else if (last && !flush_pending)  valid[base_idx] <= 1'b1;
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (ack) begin
      data_mem[base_idx][cnt] <= mem_rdata_i;
      if (last) tag_mem[base_idx] <= tag_of(base);
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && !stall_i && (hit_cnt_o != '1)) hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (start && (miss_cnt_o != '1))          miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
